// File: rtl/clkdiv_prog.sv
// Runtime-programmable clock divider: 50%-duty clock_out plus a tick on each rising edge.
// Optional macro CLKDIV_PERIOD_CNT_EN adds a saturating period_cnt output.
module clkdiv_prog #(
    parameter int          WIDTH      = 23,
    parameter int unsigned DEFAULT_TC = 4999999
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] tc_in,
    input  logic             tc_load,
    output logic             tc_busy,
    output logic             tc_ack,
    output logic [WIDTH-1:0] tc_cur,
`ifdef CLKDIV_PERIOD_CNT_EN
    output logic [15:0]      period_cnt,
`endif
    output logic             clock_out,
    output logic             tick
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] tc_cur_q, tc_cur_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             at_tc;
    logic             boundary;
    logic             apply;

    assign at_tc    = (cnt_q == tc_cur_q);
    // A period ends on the wrap that drives clock_out from 1 back to 0.
    assign boundary = enable && at_tc && clk_q;
    assign apply    = busy_q && (boundary || !enable);

    always_comb begin
        cnt_d    = cnt_q;
        clk_d    = clk_q;
        tick_d   = 1'b0;
        tc_cur_d = tc_cur_q;
        pend_d   = pend_q;
        busy_d   = busy_q;
        ack_d    = 1'b0;

        if (!enable) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (at_tc) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = ~clk_q;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end

        if (apply) begin
            tc_cur_d = pend_q;
            busy_d   = 1'b0;
            ack_d    = 1'b1;
        end

        // A load in the apply cycle becomes the next pending value.
        if (tc_load) begin
            pend_d = tc_in;
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            cnt_q    <= '0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            tc_cur_q <= WIDTH'(DEFAULT_TC);
            pend_q   <= '0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
            tc_cur_q <= tc_cur_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
        end
    end

`ifdef CLKDIV_PERIOD_CNT_EN
    logic [15:0] period_cnt_q, period_cnt_d;

    always_comb begin
        period_cnt_d = period_cnt_q;
        if (!enable) begin
            period_cnt_d = '0;
        end else if (boundary && (period_cnt_q != 16'hFFFF)) begin
            period_cnt_d = period_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

    assign clock_out = clk_q;
    assign tick      = tick_q;
    assign tc_cur    = tc_cur_q;
    assign tc_busy   = busy_q;
    assign tc_ack    = ack_q;

endmodule

// File: doc/clkdiv_prog.md
Name: clkdiv_prog

Overview:
- Runtime-programmable clock divider / tick generator; parametrised successor to the fixed divide-by-10,000,000 divider.
- Produces a 50%-duty divided clock and a one-cycle tick strobe at each divided-clock rising edge.
- Divisor is loadable at run time via a load/ack handshake; changes apply glitch-free at period boundaries.
- Feeds the datapath step clock, display refresh and debounce timing from one board clock.

Parameters:
- WIDTH, 23, width of counter and terminal-count register.
- DEFAULT_TC, 4999999, terminal count after reset; half-period = TC+1 input cycles.

Ports:
- clock_in  input  1  board clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run control: 1 = count; 0 = hold counter and clock_out cleared.
- tc_in  input  WIDTH  new terminal count.
- tc_load  input  1  one-cycle request to latch tc_in.
- tc_busy  output  1  a loaded value is pending, not yet applied.
- tc_ack  output  1  one-cycle pulse in the cycle the pending value becomes active.
- tc_cur  output  WIDTH  terminal count currently in use.
- clock_out  output  1  divided clock, period 2*(tc_cur+1) input cycles.
- tick  output  1  one-cycle strobe coincident with each clock_out 0->1 transition.

Behaviour:
- Clock and reset: one clock (clock_in); reset is synchronous and active-high.
- Reset values: counter=0, clock_out=0, tick=0, tc_cur=DEFAULT_TC, pending=0, tc_busy=0, tc_ack=0. Reset overrides every other input in the same cycle.
- Outputs: all registered; no combinational path from input to output.
- States: IDLE (enable=0) and RUN (enable=1).
  - IDLE: counter=0, clock_out=0, tick=0 every cycle.
  - IDLE -> RUN: counting starts in the first cycle enable=1. The first toggle occurs after tc_cur+1 enabled cycles.
  - RUN -> IDLE: enable low mid-period clears counter and clock_out on the next edge; no tick is issued.
- Counting in RUN:
  - counter != tc_cur: counter += 1.
  - counter == tc_cur: counter <= 0 and clock_out toggles.
  - tick=1 in the cycle clock_out becomes 1; otherwise tick=0.
- TC = 0: clock_out toggles every cycle (divide-by-2); tick is high every other cycle.
- Period boundary: the wrap where clock_out goes 1->0.
- Load handshake:
  - tc_load=1 captures tc_in into pending and sets tc_busy=1 on the next edge.
  - tc_load while busy overwrites pending (last wins); tc_busy stays 1.
  - Pending is applied at the next period boundary. In that cycle tc_cur<=pending, tc_busy<=0, tc_ack<=1 for one cycle. The new period starts with counter=0 under the new TC.
  - If enable=0, pending is applied on the edge after capture: tc_busy is high for exactly one cycle, then tc_ack pulses.
  - tc_load in the same cycle as apply: the new tc_in is captured as the next pending value; tc_busy remains 1; tc_ack still pulses for the value applied.
- Width rules: counter and TC are unsigned WIDTH bits; the counter never exceeds tc_cur, so there is no overflow.
- Reset mid-load: the pending value is discarded and no tc_ack is issued.

Optional Feature:
- Macro: CLKDIV_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt [15:0], incremented at each period boundary.
  - Saturates at 16'hFFFF; no wrap.
  - Cleared by reset and whenever enable=0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, enable=1, DEFAULT_TC overridden to 3 -> clock_out period 8 cycles (4 high/4 low); tick every 8th cycle, first tick 4 cycles after enable.
- tc_load with tc_in=1 mid-high-phase at TC=3 -> tc_busy high until the 1->0 boundary; tc_ack one cycle; next period 4 cycles; tc_cur=1.
- Two tc_load pulses (5 then 2) before a boundary -> only 2 applied; a single tc_ack.
- tc_cur=0 -> clock_out toggles every cycle; tick on alternate cycles.
- enable dropped at counter=2, TC=3, clock_out=1 -> next edge counter=0, clock_out=0, no tick. Re-enable -> first rise after 4 cycles.
- Reset asserted while tc_busy=1 -> tc_busy=0, no tc_ack, tc_cur=DEFAULT_TC. With CLKDIV_PERIOD_CNT_EN: period_cnt=0, then counts 1,2,3 over three periods.
